// File: rtl/bus_pkg.sv
// Shared types for the QSPI SRAM byte-bus arbiter and future multi-master bus work.
package bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 8;

  // Command fields latched toward QSPI_SRAM; widths track the arbiter's default AW/DW.
  typedef struct packed {
    logic              write;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational two-way picker: one-hot winner among eligible requesters,
// round-robin on `last` or fixed priority to master 0.
module bus_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  input  logic       mask0,
  output logic [1:0] win
);

  logic [1:0] elig_s;

  // Pick a winner among eligible requests; `last`=1 means master 1 won previously.
  always_comb begin
    elig_s = {req[1], req[0] & ~mask0};
    win    = 2'b00;
    case (elig_s)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11: begin
        if (rr && !last) begin
          win = 2'b10;
        end else begin
          win = 2'b01;
        end
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of QSPI_SRAM: grants whole transactions, registers the
// downstream command, and lets master 1 hold the bus across locked block transfers.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW,
  parameter bit RR = 1'b1
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          M0_REQ,
  input  logic          M0_WRITE,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RDY,
  input  logic          M1_REQ,
  input  logic          M1_WRITE,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RDY,
  input  logic          M1_LOCK,
  output logic          BUS_REQ,
  output logic          BUS_WRITE,
  output logic [AW-1:0] BUS_ADDR,
  output logic [DW-1:0] BUS_WDATA,
  input  logic [DW-1:0] BUS_RDATA,
  input  logic          BUS_RDY,
  output logic [1:0]    GRANT
);

  arb_state_t state_r;
  bus_cmd_t   cmd_r;
  bus_cmd_t   cmd_s;
  logic       last_r;
  logic       locked_r;
  logic       bus_req_r;
  logic [1:0] grant_r;
  logic [1:0] win_s;

  bus_arb_pick u_pick (
    .req   ({M1_REQ, M0_REQ}),
    .last  (last_r),
    .rr    (RR),
    .mask0 (locked_r),
    .win   (win_s)
  );

  // Select the winning master's command fields for latching.
  always_comb begin
    if (win_s[1]) begin
      cmd_s.write = M1_WRITE;
      cmd_s.addr  = M1_ADDR;
      cmd_s.wdata = M1_WDATA;
    end else begin
      cmd_s.write = M0_WRITE;
      cmd_s.addr  = M0_ADDR;
      cmd_s.wdata = M0_WDATA;
    end
  end

  // Arbitration FSM with registered downstream command, grant and lock tracking.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r   <= IDLE;
      cmd_r     <= '{write: 1'b0, addr: {BUS_AW{1'b0}}, wdata: {BUS_DW{1'b0}}};
      last_r    <= 1'b1;
      locked_r  <= 1'b0;
      bus_req_r <= 1'b0;
      grant_r   <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_s != 2'b00) begin
            cmd_r     <= cmd_s;
            bus_req_r <= 1'b1;
            grant_r   <= win_s;
            locked_r  <= 1'b0;
            state_r   <= win_s[1] ? OWN1 : OWN0;
          end else begin
            // A held lock keeps master 1 shown as owner until it lets go.
            grant_r  <= (locked_r && M1_LOCK) ? 2'b10 : 2'b00;
            locked_r <= locked_r & M1_LOCK;
          end
        end
        OWN0: begin
          if (BUS_RDY) begin
            bus_req_r <= 1'b0;
            last_r    <= 1'b0;
            grant_r   <= 2'b00;
            state_r   <= IDLE;
          end else begin
            state_r   <= OWN0;
          end
        end
        OWN1: begin
          if (BUS_RDY) begin
            bus_req_r <= 1'b0;
            last_r    <= 1'b1;
            locked_r  <= M1_LOCK;
            grant_r   <= M1_LOCK ? 2'b10 : 2'b00;
            state_r   <= IDLE;
          end else begin
            state_r   <= OWN1;
          end
        end
        default: begin
          state_r   <= IDLE;
          bus_req_r <= 1'b0;
          grant_r   <= 2'b00;
          locked_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUS_REQ   = bus_req_r;
  assign BUS_WRITE = cmd_r.write;
  assign BUS_ADDR  = cmd_r.addr;
  assign BUS_WDATA = cmd_r.wdata;
  assign GRANT     = grant_r;

  // Completion is passed through in the same cycle; a spurious BUS_RDY in IDLE reaches nobody.
  assign M0_RDY   = (state_r == OWN0) & BUS_RDY;
  assign M1_RDY   = (state_r == OWN1) & BUS_RDY;
  assign M0_RDATA = BUS_RDATA;
  assign M1_RDATA = BUS_RDATA;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic checked each cycle
// against a transaction-level reference model; a second RR=0 instance covers fixed priority.
module tb_bus_arbiter;
  import bus_pkg::*;

  logic CLK = 1'b0;
  logic RES;
  always #5 CLK = ~CLK;

  logic m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
  logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0;
  logic [7:0]  m0_wdata = 8'h0, m1_wdata = 8'h0, bus_rdata = 8'h0;
  logic        bus_rdy = 1'b0;
  logic [7:0]  m0_rdata, m1_rdata, bus_wdata;
  logic        m0_rdy, m1_rdy, bus_req, bus_write;
  logic [15:0] bus_addr;
  logic [1:0]  grant;

  logic f_m0_req = 1'b0, f_m0_write = 1'b1, f_m1_req = 1'b0, f_m1_write = 1'b0, f_m1_lock = 1'b0;
  logic [15:0] f_m0_addr = 16'h0100, f_m1_addr = 16'h0200;
  logic [7:0]  f_m0_wdata = 8'h11, f_m1_wdata = 8'h22, f_bus_rdata = 8'h0;
  logic        f_bus_rdy = 1'b0;
  logic [7:0]  f_m0_rdata, f_m1_rdata, f_bus_wdata;
  logic        f_m0_rdy, f_m1_rdy, f_bus_req, f_bus_write;
  logic [15:0] f_bus_addr;
  logic [1:0]  f_grant;

  bus_arbiter #(.AW(16), .DW(8), .RR(1'b1)) dut (
    .CLK(CLK), .RES(RES),
    .M0_REQ(m0_req), .M0_WRITE(m0_write), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_RDATA(m0_rdata), .M0_RDY(m0_rdy),
    .M1_REQ(m1_req), .M1_WRITE(m1_write), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_RDATA(m1_rdata), .M1_RDY(m1_rdy), .M1_LOCK(m1_lock),
    .BUS_REQ(bus_req), .BUS_WRITE(bus_write), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata),
    .BUS_RDATA(bus_rdata), .BUS_RDY(bus_rdy), .GRANT(grant)
  );

  bus_arbiter #(.AW(16), .DW(8), .RR(1'b0)) dut_fp (
    .CLK(CLK), .RES(RES),
    .M0_REQ(f_m0_req), .M0_WRITE(f_m0_write), .M0_ADDR(f_m0_addr), .M0_WDATA(f_m0_wdata),
    .M0_RDATA(f_m0_rdata), .M0_RDY(f_m0_rdy),
    .M1_REQ(f_m1_req), .M1_WRITE(f_m1_write), .M1_ADDR(f_m1_addr), .M1_WDATA(f_m1_wdata),
    .M1_RDATA(f_m1_rdata), .M1_RDY(f_m1_rdy), .M1_LOCK(f_m1_lock),
    .BUS_REQ(f_bus_req), .BUS_WRITE(f_bus_write), .BUS_ADDR(f_bus_addr), .BUS_WDATA(f_bus_wdata),
    .BUS_RDATA(f_bus_rdata), .BUS_RDY(f_bus_rdy), .GRANT(f_grant)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: who owns the bus (-1 = nobody), who won last, and whether master 1 holds a lock.
  int          mdl_owner, mdl_last;
  bit          mdl_lock, edge_rdy0, edge_rdy1;
  logic        exp_bus_req, exp_write;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic [1:0]  exp_grant;
  logic        prev_bus_req = 1'b0;
  int          obs_grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mdl_owner = -1; mdl_last = 1; mdl_lock = 1'b0;
    exp_bus_req = 1'b0; exp_write = 1'b0; exp_addr = 16'h0; exp_wdata = 8'h0; exp_grant = 2'b00;
  endtask

  task automatic model_edge();
    int w;
    edge_rdy0 = bus_rdy && (mdl_owner == 0);
    edge_rdy1 = bus_rdy && (mdl_owner == 1);
    if (RES) begin
      model_reset();
    end else if (mdl_owner < 0) begin
      w = -1;
      if (m0_req && !mdl_lock && m1_req) w = (mdl_last == 0) ? 1 : 0;
      else if (m0_req && !mdl_lock)      w = 0;
      else if (m1_req)                   w = 1;
      if (w >= 0) begin
        mdl_owner   = w;
        mdl_lock    = 1'b0;
        exp_bus_req = 1'b1;
        exp_write   = (w == 1) ? m1_write : m0_write;
        exp_addr    = (w == 1) ? m1_addr  : m0_addr;
        exp_wdata   = (w == 1) ? m1_wdata : m0_wdata;
        exp_grant   = (w == 1) ? 2'b10 : 2'b01;
      end else begin
        mdl_lock  = mdl_lock && m1_lock;
        exp_grant = mdl_lock ? 2'b10 : 2'b00;
      end
    end else if (bus_rdy) begin
      mdl_last    = mdl_owner;
      mdl_lock    = (mdl_owner == 1) && m1_lock;
      mdl_owner   = -1;
      exp_bus_req = 1'b0;
      exp_grant   = mdl_lock ? 2'b10 : 2'b00;
    end
  endtask

  task automatic check_regs();
    chk("bus_req", bus_req, exp_bus_req);
    chk("bus_write", bus_write, exp_write);
    chk("bus_addr", bus_addr, exp_addr);
    chk("bus_wdata", bus_wdata, exp_wdata);
    chk("grant", grant, exp_grant);
    if (bus_req === 1'b1 && prev_bus_req === 1'b0) obs_grants.push_back((grant == 2'b10) ? 1 : 0);
    prev_bus_req = bus_req;
  endtask

  task automatic check_comb();
    chk("m0_rdy", m0_rdy, bus_rdy && (mdl_owner == 0));
    chk("m1_rdy", m1_rdy, bus_rdy && (mdl_owner == 1));
    chk("m0_rdata", m0_rdata, bus_rdata);
    chk("m1_rdata", m1_rdata, bus_rdata);
  endtask

  // Inputs are set just after an edge; tick checks outputs, crosses one edge, and re-checks.
  task automatic tick();
    #1; check_comb();
    @(posedge CLK); #1;
    model_edge();
    check_regs();
  endtask

  task automatic serve(input int lat, input logic [7:0] rd, input int who);
    int n;
    n = 0;
    while (bus_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk("bus_req_wait", bus_req, 1'b1);
    repeat (lat) tick();
    bus_rdy = 1'b1; bus_rdata = rd;
    #1;
    chk("owner_rdy", (who == 1) ? m1_rdy : m0_rdy, 1'b1);
    chk("other_rdy", (who == 1) ? m0_rdy : m1_rdy, 1'b0);
    chk("owner_rdata", (who == 1) ? m1_rdata : m0_rdata, rd);
    tick();
    bus_rdy = 1'b0;
  endtask

  task automatic fp_serve(input int who, input logic [7:0] rd);
    int n;
    n = 0;
    while (f_bus_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk("fp_req_wait", f_bus_req, 1'b1);
    chk("fp_grant", f_grant, (who == 1) ? 2'b10 : 2'b01);
    chk("fp_addr", f_bus_addr, (who == 1) ? 16'h0200 : 16'h0100);
    chk("fp_write", f_bus_write, (who == 1) ? 1'b0 : 1'b1);
    chk("fp_wdata", f_bus_wdata, (who == 1) ? 8'h22 : 8'h11);
    tick();
    f_bus_rdy = 1'b1; f_bus_rdata = rd;
    #1;
    chk("fp_m0_rdy", f_m0_rdy, who == 0);
    chk("fp_m1_rdy", f_m1_rdy, who == 1);
    chk("fp_rdata", (who == 1) ? f_m1_rdata : f_m0_rdata, rd);
    tick();
    f_bus_rdy = 1'b0;
    chk("fp_req_drop", f_bus_req, 1'b0);
  endtask

  task automatic chk_order(input string tag, input int n, input logic [7:0] pat);
    chk({tag, "_count"}, obs_grants.size(), n);
    for (int i = 0; i < n; i++) chk(tag, (i < obs_grants.size()) ? obs_grants[i] : 99, pat[i]);
  endtask

  task automatic do_reset();
    RES = 1'b1; model_reset();
    tick(); tick();
    RES = 1'b0;
    obs_grants.delete();
  endtask

  initial begin
    bit pend0, pend1, slv_busy;
    int slv_cnt;

    RES = 1'b1;
    model_reset();
    tick(); tick();
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_addr", bus_addr, 16'h0000);
    chk("rst_m0_rdy", m0_rdy, 1'b0);
    RES = 1'b0;

    // Single master read with a 20-cycle slave.
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h1234;
    tick();
    chk("t1_bus_req", bus_req, 1'b1);
    chk("t1_addr", bus_addr, 16'h1234);
    chk("t1_grant", grant, 2'b01);
    serve(19, 8'hA5, 0);
    m0_req = 1'b0;
    chk("t1_req_drop", bus_req, 1'b0);
    tick();

    // Round-robin with both masters requesting continuously.
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h0010; m1_req = 1'b1; m1_addr = 16'h0020; m1_write = 1'b1; m1_wdata = 8'h99;
    for (int k = 0; k < 5; k++) begin
      serve(2, 8'h40 + 8'(k), k % 2);
      if (k % 2 == 0) m0_addr = m0_addr + 16'h1;
      else            m1_addr = m1_addr + 16'h1;
      if (k == 3) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    tick();
    chk_order("rr_order", 5, 8'b0000_1010);

    // Locked block write by master 1 while master 0 waits.
    obs_grants.delete();
    m1_req = 1'b1; m1_lock = 1'b1; m1_write = 1'b1; m1_addr = 16'h8000; m1_wdata = 8'h00;
    tick();
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h0042;
    for (int k = 0; k < 4; k++) begin
      serve(2, 8'h00, 1);
      if (k == 0) chk("lock_grant_hold", grant, 2'b10);
      m1_addr = m1_addr + 16'h1; m1_wdata = m1_wdata + 8'h1;
      if (k == 2) m1_lock = 1'b0;
      if (k == 3) m1_req = 1'b0;
    end
    serve(2, 8'h5A, 0);
    m0_req = 1'b0;
    tick();
    chk_order("lock_order", 5, 8'b0000_1111);

    // Reset two cycles into a transaction, with a BUS_RDY arriving during reset.
    m0_req = 1'b1; m0_addr = 16'h0777;
    tick(); tick(); tick();
    RES = 1'b1; bus_rdy = 1'b1; model_reset();
    #1;
    chk("rst_mid_bus_req", bus_req, 1'b0);
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_m0_rdy", m0_rdy, 1'b0);
    prev_bus_req = bus_req;
    tick();
    RES = 1'b0; bus_rdy = 1'b0; m1_req = 1'b1; m1_write = 1'b0; m1_addr = 16'h0333;
    obs_grants.delete();
    serve(1, 8'h77, 0);
    m0_req = 1'b0;
    serve(1, 8'h88, 1);
    m1_req = 1'b0;
    tick();
    chk_order("rst_order", 2, 8'b0000_0010);

    // Spurious BUS_RDY while idle, then master 1 dropping REQ early.
    bus_rdy = 1'b1;
    #1;
    chk("spur_m0_rdy", m0_rdy, 1'b0);
    chk("spur_m1_rdy", m1_rdy, 1'b0);
    tick();
    bus_rdy = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0ABC;
    tick(); tick();
    m1_req = 1'b0;
    serve(2, 8'hC3, 1);
    tick();

    // Fixed-priority instance: master 0 takes every grant while it keeps asking.
    f_m0_req = 1'b1; f_m1_req = 1'b1;
    for (int k = 0; k < 3; k++) fp_serve(0, 8'h60 + 8'(k));
    f_m0_req = 1'b0;
    fp_serve(1, 8'h6F);
    f_m1_req = 1'b0;
    tick();

    // Random traffic with a variable-latency slave and occasional spurious completions.
    pend0 = 1'b0; pend1 = 1'b0; slv_busy = 1'b0; slv_cnt = 0;
    for (int c = 0; c < 900; c++) begin
      if (edge_rdy0) pend0 = 1'b0;
      if (edge_rdy1) pend1 = 1'b0;
      if (c >= 600) m1_lock = 1'b0;
      if (c < 600 && !pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; m0_write = 1'($urandom_range(0, 1));
        m0_addr = 16'($urandom); m0_wdata = 8'($urandom);
      end
      if (c < 600 && !pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; m1_write = 1'($urandom_range(0, 1)); m1_lock = 1'($urandom_range(0, 1));
        m1_addr = 16'($urandom); m1_wdata = 8'($urandom);
      end
      m0_req = pend0; m1_req = pend1;
      bus_rdy = 1'b0;
      if (slv_busy) begin
        if (slv_cnt == 0) begin bus_rdy = 1'b1; bus_rdata = 8'($urandom); slv_busy = 1'b0; end
        else slv_cnt--;
      end else if (bus_req === 1'b1) begin
        slv_busy = 1'b1; slv_cnt = $urandom_range(0, 4);
      end else if ($urandom_range(0, 9) == 0) begin
        bus_rdy = 1'b1; bus_rdata = 8'($urandom);
      end
      if (c >= 600 && !pend0 && !pend1 && !slv_busy) break;
      tick();
    end
    bus_rdy = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();
    chk("final_bus_req", bus_req, 1'b0);
    chk("final_grant", grant, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single QSPI SRAM byte bus between the CACHE (master 0) and a second requester such as a UART program loader or debug port (master 1). It sits between the masters and QSPI_SRAM and registers the downstream request. It grants one whole transaction at a time, using round-robin or fixed priority. Master 1 can lock the bus across consecutive transactions for block loads.

## Interface
- `AW`, default 16: address width.
- `DW`, default 8: data width.
- `RR`, default 1: 1 selects round-robin; 0 selects fixed priority with master 0 winning.
- `CLK` in 1: single clock; all logic on its rising edge.
- `RES` in 1: reset, asynchronous and active-high.
- `M0_REQ` / `M1_REQ` in 1: transaction request; held high until that master's RDY.
- `M0_WRITE` / `M1_WRITE` in 1: 1 = write, 0 = read; stable while REQ is high.
- `M0_ADDR` / `M1_ADDR` in AW: byte address; stable while REQ is high.
- `M0_WDATA` / `M1_WDATA` in DW: write data; stable while REQ is high.
- `M0_RDATA` / `M1_RDATA` out DW: read data; valid only in the cycle RDY is high.
- `M0_RDY` / `M1_RDY` out 1: one-cycle completion pulse.
- `M1_LOCK` in 1: while master 1 owns the bus, keeps ownership for its next transaction.
- `BUS_REQ` out 1: registered request to QSPI_SRAM.
- `BUS_WRITE` out 1: registered write flag to QSPI_SRAM.
- `BUS_ADDR` out AW: registered address to QSPI_SRAM.
- `BUS_WDATA` out DW: registered write data to QSPI_SRAM.
- `BUS_RDATA` in DW: read data from QSPI_SRAM.
- `BUS_RDY` in 1: one-cycle completion pulse from QSPI_SRAM.
- `GRANT` out 2: one-hot current owner; 00 when idle.

## Operation
- **Bus protocol, both sides:**
  - A requester raises REQ with its command fields and holds all of them until RDY.
  - It drops REQ, or presents a new command, no earlier than the cycle after RDY.
  - The responder samples REQ only while idle.
- **FSM states:** IDLE, OWN0, OWN1.
- **IDLE:**
  - The picker chooses among the asserted REQs.
  - On a win, the arbiter latches the winner's WRITE/ADDR/WDATA into the BUS_* registers, sets BUS_REQ=1, and moves to OWNx.
- **Picker:**
  - With one requester, that requester wins.
  - With both requesting and RR=1, the master that did not win last time wins (`last` register, reset value 1, so master 0 wins first).
  - With RR=0, master 0 always wins.
- **OWNx:**
  - BUS_* registers are frozen.
  - BUS_RDY is routed combinationally to Mx_RDY, and BUS_RDATA to Mx_RDATA.
  - The other master's RDY is 0. Both RDATA outputs carry BUS_RDATA at all times; the consumer qualifies with RDY.
- **On BUS_RDY in OWNx:**
  - BUS_REQ is cleared at the next edge and `last` is set to x.
  - If x=1 and M1_LOCK=1 in the BUS_RDY cycle, the FSM returns to OWN1-wait: master 1 remains the only eligible requester.
  - Otherwise the FSM returns to IDLE.
- **OWN1-wait:**
  - Implemented as IDLE with `locked`=1.
  - Master 0 is masked.
  - `locked` clears when M1_LOCK is seen low in IDLE.
- **Early drop:** if the owner drops REQ before RDY (protocol violation), the arbiter still completes the downstream transaction and still pulses that owner's RDY.

## Timing
- **Reset values:** BUS_REQ=0, BUS_WRITE=0, BUS_ADDR=0, BUS_WDATA=0, GRANT=00, M0_RDY=0, M1_RDY=0, state=IDLE, last=1, locked=0.
- **Request latency:** master REQ seen in IDLE at edge N gives BUS_REQ=1 in cycle N+1.
- **Completion latency:** BUS_RDY in cycle M gives Mx_RDY=1 in the same cycle M (zero added latency).
- **Back-to-back transactions:** BUS_REQ is 0 in M+1. The earliest next BUS_REQ is M+2, so there is one dead cycle on the downstream bus per transaction.
- **GRANT:** changes on the same edge as BUS_REQ rises, and returns to 00 on the edge after BUS_RDY unless locked.
- **Simultaneous events:**
  - BUS_RDY together with a new REQ from the other master: the new REQ is arbitrated in IDLE at M+1 and issued at M+2.
  - BUS_RDY while not owning (spurious): ignored, no RDY pulse.
- **Reset mid-transaction:**
  - All outputs return to their reset values asynchronously.
  - QSPI_SRAM shares RES, so no downstream cleanup is needed.
  - Master RDY for the aborted transaction is never pulsed.

## Structure
- **Shared package `bus_pkg`:**
  - `bus_cmd_t` struct: write, addr[AW-1:0], wdata[DW-1:0].
  - `arb_state_t` enum: IDLE, OWN0, OWN1.
- **Sub-module `bus_arb_pick`:** combinational two-way picker.
  - Inputs: req[1:0], last, rr, mask0.
  - Output: one-hot win[1:0].
  - Reused by later multi-master bus work.
- **Top:** the FSM, command register, and RDY/RDATA routing live in bus_arbiter itself.

## Test plan
- **Single master read:** M0_REQ with addr 0x1234 read.
  - BUS_REQ=1, BUS_ADDR=0x1234, GRANT=01 the next cycle.
  - Slave returns RDATA 0xA5 with RDY after 20 cycles: M0_RDY pulses with M0_RDATA=0xA5 in the same cycle, and BUS_REQ=0 the next cycle.
- **Simultaneous requests, RR=1:**
  - Both REQ in the same cycle: M0 wins first, then M1.
  - Both requesting continuously for 4 transactions: grant order 0,1,0,1.
- **Fixed priority, RR=0:**
  - Both requesting continuously: M0 gets every grant.
  - M1 is served only in a cycle where M0_REQ=0 in IDLE.
- **Lock:**
  - M1 writes 0x00..0x03 to 0x8000..0x8003 with M1_LOCK=1 while M0_REQ is held high: all 4 writes complete before GRANT=01.
  - Dropping M1_LOCK hands the bus to M0 on the next arbitration.
- **Reset mid-transaction:**
  - Assert RES two cycles after BUS_REQ rises: BUS_REQ=0 and GRANT=00 immediately, with no RDY pulse.
  - After RES is released, M0 is granted first.
- **Spurious and early-drop cases:**
  - BUS_RDY while IDLE: no M*_RDY pulse.
  - M1 drops REQ mid-transaction: the transaction still completes and M1_RDY still pulses.
